divider_control: RTL and testbench

DIVIDER_CONTROL -- requirements
Module: divider_control

---
 rtl/divider_control.sv | 94 +++++++++
 tb/tb_divider_control.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_control.sv
// Sequencer for an 8-bit restoring divider built from bit slices.
// Walks LOAD, CHECK, eight ITER cycles, then DONE or ERR.
module divider_control (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       Start,
    input  logic       nBorrow,
    input  logic       nZ,
    input  logic       Test,
    output logic       Load,
    output logic       LoadAcc,
    output logic       LoadResult,
    output logic       ShiftDivisor,
    output logic       QuotientBit,
    output logic       Busy,
    output logic       Done,
    output logic       DivByZero,
    output logic [3:0] Step
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ITER  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t     state;
    state_t     nextState;
    logic [3:0] stepReg;
    logic       divByZeroReg;

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  if (Start) nextState = LOAD;
            LOAD:  nextState = CHECK;
            CHECK: nextState = nZ ? ITER : ERR;
            ITER:  if (stepReg == 4'd7) nextState = DONE;
            DONE:  nextState = IDLE;
            ERR:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Test freezes state and counters; reset still wins over it.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state        <= IDLE;
            stepReg      <= 4'd0;
            divByZeroReg <= 1'b0;
        end else if (!Test) begin
            state <= nextState;
            if (nextState == LOAD) begin
                stepReg      <= 4'd0;
                divByZeroReg <= 1'b0;
            end else if (state == ITER) begin
                stepReg <= stepReg + 4'd1;
            end
            if (nextState == ERR) divByZeroReg <= 1'b1;
        end
    end

    always_comb begin
        Load         = 1'b0;
        LoadAcc      = 1'b0;
        LoadResult   = 1'b0;
        ShiftDivisor = 1'b0;
        QuotientBit  = 1'b0;
        Busy         = (state != IDLE);
        Done         = (state == DONE) || (state == ERR);
        DivByZero    = divByZeroReg;
        Step         = stepReg;
        if (!Test) begin
            unique case (state)
                LOAD: begin
                    Load    = 1'b1;
                    LoadAcc = 1'b1;
                end
                // Restoring step: ACC only takes the difference on no-borrow.
                ITER: begin
                    LoadResult   = 1'b1;
                    ShiftDivisor = 1'b1;
                    QuotientBit  = nBorrow;
                    LoadAcc      = nBorrow;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_control.sv
// Directed bench for divider_control: per-cycle vector table
// plus hand sequences for reset abort, scan freeze and held Start.
module tb_divider_control;

    logic       Clock = 1'b0;
    logic       nReset;
    logic       Start;
    logic       nBorrow;
    logic       nZ;
    logic       Test;
    logic       Load;
    logic       LoadAcc;
    logic       LoadResult;
    logic       ShiftDivisor;
    logic       QuotientBit;
    logic       Busy;
    logic       Done;
    logic       DivByZero;
    logic [3:0] Step;

    int nChecks = 0;
    int nFails  = 0;

    divider_control dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .Start       (Start),
        .nBorrow     (nBorrow),
        .nZ          (nZ),
        .Test        (Test),
        .Load        (Load),
        .LoadAcc     (LoadAcc),
        .LoadResult  (LoadResult),
        .ShiftDivisor(ShiftDivisor),
        .QuotientBit (QuotientBit),
        .Busy        (Busy),
        .Done        (Done),
        .DivByZero   (DivByZero),
        .Step        (Step)
    );

    always #5 Clock = ~Clock;

    // {Load,LoadAcc,LoadResult,ShiftDivisor,QuotientBit,Busy,Done,DivByZero,Step}
    typedef struct {
        logic       start;
        logic       nb;
        logic       nz;
        logic       tst;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[20];

    function automatic logic [11:0] outs();
        return {Load, LoadAcc, LoadResult, ShiftDivisor, QuotientBit,
                Busy, Done, DivByZero, Step};
    endfunction

    function automatic vec_t mk(logic s, logic b, logic z, logic t,
                                logic [7:0] f, logic [3:0] st);
        vec_t v;
        v.start = s;
        v.nb    = b;
        v.nz    = z;
        v.tst   = t;
        v.exp   = {f, st};
        return v;
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic s, logic b, logic z, logic t);
        Start   = s;
        nBorrow = b;
        nZ      = z;
        Test    = t;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        nReset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        nReset = 1'b1;
    endtask

    logic [7:0] bits;
    int         doneAt;
    int         doneCnt;

    initial begin
        bits = 8'b0100_1101;
        tbl[0]  = mk(1, 0, 1, 0, 8'b0000_0000, 4'd0);
        tbl[1]  = mk(0, 1, 1, 0, 8'b1100_0100, 4'd0);
        tbl[2]  = mk(0, 1, 1, 0, 8'b0000_0100, 4'd0);
        for (int k = 0; k < 8; k++) begin
            tbl[3+k] = mk(0, bits[k], 1, 0,
                          {1'b0, bits[k], 2'b11, bits[k], 3'b100},
                          4'(k));
        end
        tbl[5].start = 1'b1;
        tbl[7].nz    = 1'b0;
        tbl[11] = mk(0, 1, 1, 0, 8'b0000_0110, 4'd8);
        tbl[12] = mk(0, 1, 1, 0, 8'b0000_0000, 4'd8);
        tbl[13] = mk(1, 0, 1, 0, 8'b0000_0000, 4'd8);
        tbl[14] = mk(0, 1, 0, 0, 8'b1100_0100, 4'd0);
        tbl[15] = mk(0, 1, 0, 0, 8'b0000_0100, 4'd0);
        tbl[16] = mk(1, 1, 0, 0, 8'b0000_0111, 4'd0);
        tbl[17] = mk(0, 0, 1, 0, 8'b0000_0001, 4'd0);
        tbl[18] = mk(1, 0, 1, 0, 8'b0000_0001, 4'd0);
        tbl[19] = mk(0, 0, 1, 0, 8'b1100_0100, 4'd0);

        nReset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        nReset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("reset", outs(), 12'h000);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].start, tbl[i].nb, tbl[i].nz, tbl[i].tst);
            #1;
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
            tick();
        end

        // Reset on the fourth ITER cycle abandons the operation.
        doReset();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        tick();
        tick();
        #1;
        check("iter4_step", {8'h00, Step}, 12'h003);
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        #1;
        check("abort_outs", outs(), 12'h000);
        doneCnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (Done) doneCnt++;
            tick();
        end
        check("abort_nodone", 12'(doneCnt), 12'h000);

        // Scan freeze for 5 cycles at Step=3 delays Done by 5.
        doReset();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c < 6; c++) tick();
        Test = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("freeze%0d", c), outs(), 12'b0000_0100_0011);
            tick();
        end
        Test   = 1'b0;
        doneAt = -1;
        for (int c = 11; c < 24; c++) begin
            #1;
            if (Done && doneAt < 0) doneAt = c;
            tick();
        end
        check("freeze_done_cycle", 12'(doneAt), 12'd16);

        // Start held high: one IDLE cycle between operations.
        doReset();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        doneCnt = 0;
        for (int c = 0; c < 30; c++) begin
            nBorrow = c[0];
            #1;
            if (Done) begin
                doneCnt++;
                if (doneCnt == 1)
                    check("held_done1", 12'(c), 12'd11);
                else if (doneCnt == 2)
                    check("held_done2", 12'(c), 12'd23);
            end
            if (c == 12) check("held_idle_gap", {11'h0, Busy}, 12'h000);
            if (c == 13) check("held_reload", outs(), 12'b1100_0100_0000);
            tick();
        end
        check("held_done_count", 12'(doneCnt), 12'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
